// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS-subset CPU; define OVF_TRAP_EN to trap signed overflow on add/addi
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 2'd0
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 2'd1
`endif
`ifndef ALU_OP_OR
`define ALU_OP_OR 2'd2
`endif
`ifndef ALU_OP_LUI
`define ALU_OP_LUI 2'd3
`endif

module mc_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] instr_i,
    input  logic        alu_zero_i,
    input  logic        alu_positive_i,
    input  logic        alu_overflow_i,
    input  logic        mem_ready_i,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        reg_we_o,
    output logic [1:0]  pc_src_o,
    output logic        alu_src_a_o,
    output logic [2:0]  alu_src_b_o,
    output logic [1:0]  alu_ctl_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        illegal_o,
    output logic [31:0] retired_o
`ifdef OVF_TRAP_EN
    ,
    output logic        exc_ovf_o
`endif
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] retired_q;
    logic        retire;
    logic [5:0]  op, fn;
    logic        is_r, r_ok, r_sub, r_or;
    logic        is_addi, is_addiu, is_ori, is_lui, is_alui;
    logic        is_lw, is_sw, is_beq, is_bgtz, is_j;
    logic        unused_bits;

    assign op        = instr_i[31:26];
    assign fn        = instr_i[5:0];
    assign is_r      = op == 6'h00;
    assign r_sub     = fn == 6'h22 || fn == 6'h23;
    assign r_or      = fn == 6'h25;
    assign r_ok      = is_r && (fn == 6'h20 || fn == 6'h21 || r_sub || r_or);
    assign is_addi   = op == 6'h08;
    assign is_addiu  = op == 6'h09;
    assign is_ori    = op == 6'h0D;
    assign is_lui    = op == 6'h0F;
    assign is_alui   = is_addi || is_addiu || is_ori || is_lui;
    assign is_lw     = op == 6'h23;
    assign is_sw     = op == 6'h2B;
    assign is_beq    = op == 6'h04;
    assign is_bgtz   = op == 6'h07;
    assign is_j      = op == 6'h02;
    assign retired_o = retired_q;

`ifdef OVF_TRAP_EN
    logic ovf_q;
    assign unused_bits = ^instr_i[25:6];
`else
    assign unused_bits = ^{instr_i[25:6], alu_overflow_i};
`endif

    // Next state and per-state datapath controls; everything idles at zero while in reset
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_re_o     = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        reg_we_o     = 1'b0;
        pc_src_o     = 2'd0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 3'd0;
        alu_ctl_o    = `ALU_OP_ADD;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        illegal_o    = 1'b0;
`ifdef OVF_TRAP_EN
        exc_ovf_o    = 1'b0;
`endif
        if (rst_n_i) begin
            case (state_q)
                FETCH: begin
                    mem_re_o    = 1'b1;
                    alu_src_b_o = 3'd1;
                    ir_we_o     = mem_ready_i;
                    pc_we_o     = mem_ready_i;
                    state_d     = mem_ready_i ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_b_o = 3'd3;
                    illegal_o   = !(r_ok || is_alui || is_lw || is_sw || is_beq || is_bgtz || is_j);
                    state_d     = r_ok              ? EXEC_R   :
                                  is_alui           ? EXEC_I   :
                                  is_lw || is_sw    ? MEM_ADDR :
                                  is_beq || is_bgtz ? BRANCH   :
                                  is_j              ? JUMP     : FETCH;
                end
                EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_ctl_o   = r_sub ? `ALU_OP_SUB : r_or ? `ALU_OP_OR : `ALU_OP_ADD;
                    state_d     = ALU_WB;
                end
                EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = is_ori || is_lui ? 3'd4 : 3'd2;
                    alu_ctl_o   = is_ori ? `ALU_OP_OR : is_lui ? `ALU_OP_LUI : `ALU_OP_ADD;
                    state_d     = ALU_WB;
                end
                ALU_WB: begin
`ifdef OVF_TRAP_EN
                    reg_we_o  = !ovf_q;
                    exc_ovf_o = ovf_q;
`else
                    reg_we_o  = 1'b1;
`endif
                    reg_dst_o = is_r;
                    retire    = 1'b1;
                    state_d   = FETCH;
                end
                MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 3'd2;
                    state_d     = is_lw ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    mem_re_o = 1'b1;
                    iord_o   = 1'b1;
                    state_d  = mem_ready_i ? MEM_WB : MEM_RD;
                end
                MEM_WB: begin
                    reg_we_o     = 1'b1;
                    mem_to_reg_o = 1'b1;
                    retire       = 1'b1;
                    state_d      = FETCH;
                end
                MEM_WR: begin
                    mem_we_o = 1'b1;
                    iord_o   = 1'b1;
                    retire   = mem_ready_i;
                    state_d  = mem_ready_i ? FETCH : MEM_WR;
                end
                BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = is_beq ? 3'd0 : 3'd5;
                    alu_ctl_o   = `ALU_OP_SUB;
                    pc_src_o    = 2'd1;
                    pc_we_o     = is_beq ? alu_zero_i : alu_positive_i;
                    retire      = 1'b1;
                    state_d     = FETCH;
                end
                JUMP: begin
                    pc_we_o  = 1'b1;
                    pc_src_o = 2'd2;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State register and retired-instruction counter; reset abandons the instruction in flight
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire)
                retired_q <= retired_q + 32'd1;
        end
    end

`ifdef OVF_TRAP_EN
    // Capture signed overflow of add/addi during execute so write-back can suppress the write
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            ovf_q <= 1'b0;
        else if (state_q == EXEC_R || state_q == EXEC_I)
            ovf_q <= alu_overflow_i && ((is_r && fn == 6'h20) || is_addi);
    end
`endif

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the course MIPS-subset CPU: a synchronous FSM that decodes the instruction register and, cycle by cycle, drives the datapath mux selects, the register-file, PC and memory enables, and the 2-bit `alu_ctl` consumed by the ALU. It samples the ALU's `zero`/`positive`/`overflow` flags to resolve branches and overflow traps, and stalls on a memory ready handshake. It sits directly upstream of the ALU, and no other block drives `alu_ctl`.

## Interface
- No parameters; `alu_ctl` encodings come from the shared defines `ALU_OP_ADD`, `ALU_OP_SUB`, `ALU_OP_OR` and `ALU_OP_LUI`.
- `clk`  in  1  — the single clock.
- `rst_n`  in  1  — synchronous, active-low reset.
- `instr`  in  32  — IR contents; opcode `[31:26]`, funct `[5:0]`.
- `alu_zero`, `alu_positive`, `alu_overflow`  in  1 each  — combinational ALU flags.
- `mem_ready`  in  1  — memory completes the current access this cycle.
- `mem_re`, `mem_we`  out  1  — memory read and write strobes.
- `iord`  out  1  — memory address select: 0 = PC, 1 = ALUOut.
- `ir_we`, `pc_we`, `reg_we`  out  1  — write enables for the IR, PC and register file.
- `pc_src`  out  2  — next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `alu_src_a`  out  1  — ALU A select: 0 = PC, 1 = rs.
- `alu_src_b`  out  3  — ALU B select: 0 = rt, 1 = const 4, 2 = sext(imm), 3 = sext(imm)<<2, 4 = zext(imm), 5 = 0.
- `alu_ctl`  out  2  — ALU operation.
- `reg_dst`  out  1  — destination register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  — write-back data: 0 = ALUOut, 1 = MDR.
- `illegal`  out  1  — one-cycle pulse on an undecodable instruction.
- `retired`  out  32  — count of completed instructions.
- `exc_ovf`  out  1  — one-cycle pulse on a trapped overflow; present only with `OVF_TRAP_EN`.

## Operation
- Supported instructions:
  - R-type (opcode 0): add 0x20, addu 0x21, sub 0x22, subu 0x23, or 0x25.
  - I-type: addi 0x08, addiu 0x09, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bgtz 0x07.
  - J-type: j 0x02.
- Unless a state lists otherwise: all enables and strobes are 0, all selects are 0, and `alu_ctl` = ADD.
- FETCH: `mem_re`=1, `iord`=0, A=PC, B=4, ADD, `pc_src`=0.
  - When `mem_ready`=1: `ir_we`=1, `pc_we`=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: A=PC, B=sext<<2, ADD; the datapath latches the branch target into ALUOut.
  - Next state by instruction: R-type → EXEC_R; addi/addiu/ori/lui → EXEC_I; lw/sw → MEM_ADDR; beq/bgtz → BRANCH; j → JUMP.
  - Any other opcode, or an unsupported R-type funct: `illegal`=1 for one cycle, go to FETCH; not counted in `retired`.
- EXEC_R: A=rs, B=rt; `alu_ctl` = ADD for add/addu, SUB for sub/subu, OR for or. Go to ALU_WB.
- EXEC_I: A=rs; addi/addiu use B=sext with ADD; ori uses B=zext with OR; lui uses B=zext with LUI. Go to ALU_WB.
- In EXEC_R/EXEC_I the internal flop `ovf_q` is loaded with `alu_overflow` for add/addi, and with 0 for all other instructions.
- ALU_WB: `reg_we`=1 (subject to Configuration), `mem_to_reg`=0, `reg_dst`=1 for R-type, 0 for I-type. Go to FETCH.
- MEM_ADDR: A=rs, B=sext, ADD. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_re`=1, `iord`=1; hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_we`=1, `mem_to_reg`=1, `reg_dst`=0. Go to FETCH.
- MEM_WR: `mem_we`=1, `iord`=1; hold until `mem_ready`, then go to FETCH.
- BRANCH: A=rs, SUB, `pc_src`=1.
  - beq: B=rt, `pc_we`=`alu_zero`.
  - bgtz: B=0, `pc_we`=`alu_positive`.
  - Go to FETCH.
- JUMP: `pc_we`=1, `pc_src`=2. Go to FETCH.
- `retired` increments by 1 on every transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP. It wraps 0xFFFFFFFF → 0.

## Timing
- The state register, `ovf_q` and `retired` update on the rising edge of `clk`.
- All other outputs are decoded combinationally from state and inputs. The decode is Mealy only for `pc_we`/`ir_we` in FETCH and `pc_we` in BRANCH.
- Reset: on a clock edge with `rst_n`=0, state ← FETCH, `retired` ← 0, `ovf_q` ← 0.
  - While `rst_n`=0, every enable, strobe and pulse output is forced to 0 and every select to 0, with `alu_ctl` = ADD.
  - Reset asserted mid-instruction (including during a memory stall) abandons the instruction; no write occurs in the reset cycle.
- Cycle counts with zero wait states:
  - j: 3 cycles; beq/bgtz: 3.
  - R-type, I-type ALU, and sw: 4.
  - lw: 5.
- Each `mem_ready`=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle; outputs are held stable during the stall.
- `mem_ready` arriving outside FETCH/MEM_RD/MEM_WR is ignored.

## Configuration
- Macro `OVF_TRAP_EN`.
- Defined: in ALU_WB, `reg_we` = !`ovf_q`; `exc_ovf` = `ovf_q` for that one cycle. The instruction still counts in `retired`, and the next state is FETCH.
- Undefined: the `exc_ovf` port is absent, `ovf_q` is not built, and add/addi write back unconditionally, identical to addu/addiu.

## Test plan
- Reset, then `rst_n`=1 with `mem_ready`=1 and `instr`=0x00851020 (add $2,$4,$5): states FETCH→DECODE→EXEC_R→ALU_WB. EXEC_R drives `alu_ctl`=ADD, `alu_src_b`=0. ALU_WB drives `reg_we`=1, `reg_dst`=1. `retired`=1 after cycle 4.
- lw 0x8C430008 with `mem_ready` held 0 for 3 cycles in MEM_RD: `mem_re`=1 and `iord`=1 stable throughout; MEM_WB drives `reg_we`=1, `mem_to_reg`=1; 8 cycles in total.
- beq 0x10850003 with `alu_zero`=1 in BRANCH gives `pc_we`=1, `pc_src`=1; repeated with `alu_zero`=0 gives `pc_we`=0. bgtz 0x1C800002 with `alu_positive`=1 gives `pc_we`=1 and B select 5.
- `instr`=0xFC000000: `illegal` pulses for 1 cycle out of DECODE, next state is FETCH, `retired` unchanged.
- With `OVF_TRAP_EN`: addi 0x20A27FFF with `alu_overflow`=1 in EXEC_I gives `reg_we`=0 and `exc_ovf`=1 in ALU_WB. With the same stimulus and `OVF_TRAP_EN` undefined, `reg_we`=1.
- Assert `rst_n`=0 during a MEM_WR stall: `mem_we`=0 in that cycle, state=FETCH and `retired`=0 afterwards; preload `retired`=0xFFFFFFFF (force), retire one j, and `retired`=0.
